// File: rtl/kf_frame_sequencer_pkg.sv
// Shared types and defaults for the Kalman-filter frame sequencer.
// Fixed-point format Q(N,FRAC), FSM encoding and watchdog sizing.
package kf_frame_sequencer_pkg;

    localparam int FXP_N           = 20;
    localparam int FXP_FRAC        = 10;
    localparam int TIMEOUT_DEFAULT = 40;
    localparam int CNT_W_DEFAULT   = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_COMMIT = 2'd3
    } seq_state_e;

    function automatic int wdog_width(input int t);
        return (t < 2) ? 1 : $clog2(t);
    endfunction

endpackage

// File: rtl/kf_frame_watchdog.sv
// Frame watchdog: cleared at frame start, counts while enabled,
// flags expiry on the last allowed wait cycle and holds there.
module kf_frame_watchdog
    import kf_frame_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int W = wdog_width(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign expire_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/kf_frame_sequencer.sv
// Closed-loop frame controller for top_kf: accepts a sample, starts the
// filter, waits for done (with watchdog) and commits X_post as x_prev.
module kf_frame_sequencer
    import kf_frame_sequencer_pkg::*;
#(
    parameter int N              = FXP_N,
    parameter int FRAC           = FXP_FRAC,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int CNT_W          = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [N-1:0]     s_u00,
    input  logic [N-1:0]     s_z00,
    input  logic [N-1:0]     s_z10,
    output logic             kf_start,
    input  logic             kf_done,
    output logic [N-1:0]     kf_x00_prev,
    output logic [N-1:0]     kf_x10_prev,
    output logic [N-1:0]     kf_u00,
    output logic [N-1:0]     kf_u10,
    output logic [N-1:0]     kf_z00,
    output logic [N-1:0]     kf_z10,
    input  logic [N-1:0]     kf_X00_post,
    input  logic [N-1:0]     kf_X10_post,
    output logic             est_valid,
    output logic [N-1:0]     est_x00,
    output logic [N-1:0]     est_x10,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    if (FRAC < 0 || FRAC >= N) begin : g_bad_frac
        $error("kf_frame_sequencer: FRAC must lie in [0, N)");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("kf_frame_sequencer: TIMEOUT_CYCLES must be >= 1");
    end

    seq_state_e state_q;
    seq_state_e state_d;

    logic [N-1:0]     xp00_q, xp10_q;
    logic [N-1:0]     u00_q, z00_q, z10_q;
    logic [CNT_W-1:0] frame_cnt_q, drop_cnt_q;
    logic             terr_q;
    logic             clr_pend_q;

    logic is_idle;
    logic accept;
    logic capture;
    logic abort;
    logic clr_now;
    logic wd_expire;

    assign is_idle = (state_q == ST_IDLE);
    // A clear raised mid-frame is held off until the frame retires.
    assign clr_now = is_idle && (clear || clr_pend_q);
    assign s_ready = rst_n && is_idle && !clear && !clr_pend_q;

    kf_frame_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (state_q == ST_START),
        .en_i    (state_q == ST_WAIT),
        .expire_o(wd_expire)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (s_valid && s_ready) begin
                    accept  = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // done beats a coincident timeout
                if (kf_done) begin
                    capture = 1'b1;
                    state_d = ST_COMMIT;
                end else if (wd_expire) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            xp00_q      <= '0;
            xp10_q      <= '0;
            u00_q       <= '0;
            z00_q       <= '0;
            z10_q       <= '0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            terr_q      <= 1'b0;
            clr_pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                u00_q <= s_u00;
                z00_q <= s_z00;
                z10_q <= s_z10;
            end
            if (clr_now) begin
                xp00_q <= '0;
                xp10_q <= '0;
            end else if (capture) begin
                xp00_q <= kf_X00_post;
                xp10_q <= kf_X10_post;
            end
            if (clr_now) begin
                terr_q <= 1'b0;
            end else if (abort) begin
                terr_q <= 1'b1;
            end
            if (clear && !is_idle) begin
                clr_pend_q <= 1'b1;
            end else if (clr_now) begin
                clr_pend_q <= 1'b0;
            end
            if (state_q == ST_COMMIT) begin
                frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            end
            if (abort) begin
                drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            end
        end
    end

    assign kf_start    = (state_q == ST_START);
    assign est_valid   = (state_q == ST_COMMIT);
    assign busy        = !is_idle;
    assign kf_x00_prev = xp00_q;
    assign kf_x10_prev = xp10_q;
    assign est_x00     = xp00_q;
    assign est_x10     = xp10_q;
    assign kf_u00      = u00_q;
    assign kf_u10      = '0;
    assign kf_z00      = z00_q;
    assign kf_z10      = z10_q;
    assign timeout_err = terr_q;
    assign frame_cnt   = frame_cnt_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_kf_frame_sequencer.sv
// Directed bench for kf_frame_sequencer; top_kf is replaced by
// bench-driven done/X_post so every expected value is chosen here.
module tb_kf_frame_sequencer;

    localparam int N = 20;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          clear = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [N-1:0]  s_u00 = '0, s_z00 = '0, s_z10 = '0;
    logic          kf_start;
    logic          kf_done = 1'b0;
    logic [N-1:0]  kf_x00_prev, kf_x10_prev;
    logic [N-1:0]  kf_u00, kf_u10, kf_z00, kf_z10;
    logic [N-1:0]  kf_X00_post = '0, kf_X10_post = '0;
    logic          est_valid;
    logic [N-1:0]  est_x00, est_x10;
    logic          busy;
    logic          timeout_err;
    logic [CW-1:0] frame_cnt, drop_cnt;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    kf_frame_sequencer dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_u00(s_u00), .s_z00(s_z00), .s_z10(s_z10),
        .kf_start(kf_start), .kf_done(kf_done),
        .kf_x00_prev(kf_x00_prev), .kf_x10_prev(kf_x10_prev),
        .kf_u00(kf_u00), .kf_u10(kf_u10),
        .kf_z00(kf_z00), .kf_z10(kf_z10),
        .kf_X00_post(kf_X00_post), .kf_X10_post(kf_X10_post),
        .est_valid(est_valid), .est_x00(est_x00), .est_x10(est_x10),
        .busy(busy), .timeout_err(timeout_err),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] fx(input int v);
        return N'(v);
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_frame(input int u, input int p0, input int p1);
        s_valid = 1'b1;
        s_u00 = fx(u);
        s_z00 = fx(-u);
        s_z10 = fx(u + 3);
        tick();
        chk("frm_start", kf_start, 1);
        s_valid = 1'b0;
        tick();
        chk("frm_start_1cyc", kf_start, 0);
        repeat (4) tick();
        kf_done = 1'b1;
        kf_X00_post = fx(p0);
        kf_X10_post = fx(p1);
        tick();
        chk("frm_est_valid", est_valid, 1);
        chk("frm_est00", est_x00, fx(p0));
        chk("frm_est10", est_x10, fx(p1));
        kf_done = 1'b0;
        kf_X00_post = fx(32'h5A5A5);
        kf_X10_post = fx(32'h0A5A5);
        tick();
        chk("frm_est_pulse", est_valid, 0);
    endtask

    int p00 [4] = '{1200, -340, 9001, -15};
    int p10 [4] = '{-77, 4096, -2048, 511};
    int uu  [4] = '{100, -2500, 7000, 1};
    int prev0, prev1, last_start, n;
    bit seen;

    initial begin
        // reset
        #2 rst_n = 1'b0;
        repeat (5) tick();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_kf_start", kf_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_est_valid", est_valid, 0);
        chk("rst_est00", est_x00, 0);
        chk("rst_kf_u00", kf_u00, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_terr", timeout_err, 0);
        rst_n = 1'b1;
        tick();
        chk("rel_s_ready", s_ready, 1);
        chk("rel_busy", busy, 0);

        // single frame: 5.0, -1.25, 0.001 in Q10
        s_valid = 1'b1;
        s_u00 = fx(5120);
        s_z00 = fx(-1280);
        s_z10 = fx(1);
        tick();
        s_valid = 1'b0;
        s_u00 = fx(999);
        chk("sf_start", kf_start, 1);
        chk("sf_busy", busy, 1);
        chk("sf_u00", kf_u00, fx(5120));
        chk("sf_z00", kf_z00, fx(-1280));
        chk("sf_z10", kf_z10, fx(1));
        chk("sf_u10", kf_u10, 0);
        chk("sf_ready", s_ready, 0);
        tick();
        chk("sf_start_1cyc", kf_start, 0);
        repeat (3) tick();
        chk("sf_u00_stable", kf_u00, fx(5120));
        kf_done = 1'b1;
        kf_X00_post = fx(3000);
        kf_X10_post = fx(-700);
        tick();
        kf_done = 1'b0;
        kf_X00_post = '0;
        kf_X10_post = '0;
        chk("sf_est_valid", est_valid, 1);
        chk("sf_est00", est_x00, fx(3000));
        chk("sf_est10", est_x10, fx(-700));
        tick();
        chk("sf_est_pulse", est_valid, 0);
        chk("sf_frame_cnt", frame_cnt, 1);
        chk("sf_xprev00", kf_x00_prev, fx(3000));
        chk("sf_xprev10", kf_x10_prev, fx(-700));
        prev0 = 3000;
        prev1 = -700;

        // closed loop, s_valid held, 36-cycle filter
        s_valid = 1'b1;
        s_u00 = fx(uu[0]);
        tick();
        last_start = 0;
        for (int k = 0; k < 4; k++) begin
            chk("cl_start", kf_start, 1);
            chk("cl_u00", kf_u00, fx(uu[k]));
            chk("cl_xprev00", kf_x00_prev, fx(prev0));
            chk("cl_xprev10", kf_x10_prev, fx(prev1));
            if (k > 0) chk("cl_spacing", cyc - last_start, 39);
            last_start = cyc;
            repeat (36) tick();
            kf_done = 1'b1;
            kf_X00_post = fx(p00[k]);
            kf_X10_post = fx(p10[k]);
            tick();
            kf_done = 1'b0;
            chk("cl_est_valid", est_valid, 1);
            chk("cl_est10", est_x10, fx(p10[k]));
            prev0 = p00[k];
            prev1 = p10[k];
            if (k < 3) s_u00 = fx(uu[k+1]);
            else s_valid = 1'b0;
            tick();
            if (k < 3) tick();
        end
        chk("cl_frame_cnt", frame_cnt, 5);
        chk("cl_drop_cnt", drop_cnt, 0);

        // timeout
        s_valid = 1'b1;
        s_u00 = fx(7);
        tick();
        s_valid = 1'b0;
        chk("to_start", kf_start, 1);
        n = 0;
        seen = 1'b0;
        while (busy && n < 100) begin
            tick();
            n++;
            if (est_valid) seen = 1'b1;
        end
        chk("to_cycles", n, 41);
        chk("to_no_est", seen, 0);
        chk("to_terr", timeout_err, 1);
        chk("to_drop", drop_cnt, 1);
        chk("to_frame", frame_cnt, 5);
        chk("to_xprev00", kf_x00_prev, fx(prev0));
        chk("to_est10", est_x10, fx(prev1));
        do_frame(11, 222, -333);
        chk("to_next_frame", frame_cnt, 6);
        chk("to_terr_sticky", timeout_err, 1);

        // spurious done in IDLE
        kf_done = 1'b1;
        kf_X00_post = fx(-1);
        tick();
        kf_done = 1'b0;
        tick();
        chk("sp_busy", busy, 0);
        chk("sp_est00", est_x00, fx(222));
        chk("sp_frame", frame_cnt, 6);

        // done coincident with the timeout edge
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        repeat (40) tick();
        kf_done = 1'b1;
        kf_X00_post = fx(4444);
        kf_X10_post = fx(-5555);
        tick();
        kf_done = 1'b0;
        chk("sim_est_valid", est_valid, 1);
        chk("sim_est00", est_x00, fx(4444));
        chk("sim_drop", drop_cnt, 1);
        tick();
        chk("sim_frame", frame_cnt, 7);

        // clear while waiting
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (3) tick();
        kf_done = 1'b1;
        kf_X00_post = fx(808);
        kf_X10_post = fx(-909);
        tick();
        kf_done = 1'b0;
        chk("clr_est_valid", est_valid, 1);
        chk("clr_est00", est_x00, fx(808));
        tick();
        tick();
        chk("clr_xprev00", kf_x00_prev, 0);
        chk("clr_xprev10", kf_x10_prev, 0);
        chk("clr_terr", timeout_err, 0);
        chk("clr_frame", frame_cnt, 8);

        // reset while waiting
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("rw_start", kf_start, 0);
        chk("rw_busy", busy, 0);
        chk("rw_est_valid", est_valid, 0);
        chk("rw_frame", frame_cnt, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rw_ready", s_ready, 1);
        do_frame(-40, 61, 62);
        chk("rw_frame_after", frame_cnt, 1);
        chk("rw_xprev10", kf_x10_prev, fx(62));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
